// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM port arbiter family: FSM encoding,
// default widths and the watchdog counter size.
package sdram_pkg;

  localparam int AW_DEF      = 21;
  localparam int DW_DEF      = 16;
  localparam int LW_DEF      = 8;
  localparam int TIMEOUT_DEF = 4095;
  localparam int TOW         = 12;  // watchdog counter width

  // One-hot burst FSM encoding, also exported on the debug port.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_XFER  = 4'b0100,
    ST_DONE  = 4'b1000
  } arb_state_t;

  // Width of a port index; a single-port build still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: the first requester at or after ptr wins, wrapping
// modulo NPORT. Purely combinational so it can be shared by other arbiters.
module rr_pick
  import sdram_pkg::*;
#(
  parameter int NPORT = 2,
  parameter int IW    = idx_width(NPORT)
) (
  input  logic [NPORT-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [NPORT-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);

  // Scan offsets 0..NPORT-1 from ptr; the first hit sets the one-hot grant.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int off = 0; off < NPORT; off++) begin
      for (int i = 0; i < NPORT; i++) begin
        if (!any && req[i] && (i == ((int'(ptr) + off) % NPORT))) begin
          any    = 1'b1;
          gnt[i] = 1'b1;
          idx    = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller command/data interface between NPORT burst
// requesters. Handshake: a port raises req (with we/addr/len stable) and
// holds it until gnt; the arbiter pulses wr_trig/rd_trig once, steers the
// controller's beat strobes to the granted port only, and pulses done (plus
// err if the watchdog fired) for one cycle before releasing gnt.
module sdram_port_arbiter
  import sdram_pkg::*;
#(
  parameter int NPORT   = 2,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int LW      = LW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                sclk,
  input  logic                srst_n,
  input  logic [NPORT-1:0]    req,
  input  logic [NPORT-1:0]    req_we,
  input  logic [NPORT*AW-1:0] req_addr,
  input  logic [NPORT*LW-1:0] req_len,
  input  logic [NPORT*DW-1:0] req_wdata,
  output logic [NPORT-1:0]    gnt,
  output logic [NPORT-1:0]    port_wdata_en,
  output logic [DW-1:0]       port_rdata,
  output logic [NPORT-1:0]    port_rdata_vld,
  output logic [NPORT-1:0]    done,
  output logic [NPORT-1:0]    err,
  output logic                wr_trig,
  output logic                rd_trig,
  output logic [LW-1:0]       wr_len,
  output logic [LW-1:0]       rd_len,
  output logic [AW-1:0]       wr_addr,
  output logic [AW-1:0]       rd_addr,
  output logic [DW-1:0]       wr_data,
  input  logic                wr_data_en,
  input  logic [DW-1:0]       rd_data,
  input  logic                rd_data_en,
  output arb_state_t          dbg_state
);

  localparam int             IW         = idx_width(NPORT);
  localparam logic [TOW-1:0] IDLE_LIMIT = TOW'(TIMEOUT - 1);

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    ptr_q, idx_q;
  logic             we_q, abort_q;
  logic [AW-1:0]    addr_q;
  logic [LW-1:0]    len_q, beat_q;
  logic [TOW-1:0]   idle_q;
  logic [NPORT-1:0] gnt_q;
  logic             wr_trig_q, rd_trig_q;

  logic [NPORT-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [AW-1:0]    addr_arr  [NPORT];
  logic [LW-1:0]    len_arr   [NPORT];
  logic [DW-1:0]    wdata_arr [NPORT];
  logic [AW-1:0]    sel_addr;
  logic [LW-1:0]    sel_len;
  logic             sel_we;
  logic             strobe, last_beat, timeout;

  rr_pick #(.NPORT(NPORT), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Unpack the per-port buses into arrays indexed by port number.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      addr_arr[i]  = req_addr[i*AW +: AW];
      len_arr[i]   = req_len[i*LW +: LW];
      wdata_arr[i] = req_wdata[i*DW +: DW];
    end
  end

  assign sel_addr  = addr_arr[pick_idx];
  assign sel_len   = len_arr[pick_idx];
  assign sel_we    = req_we[pick_idx];
  // Only strobes in the latched direction count; the other one is ignored.
  assign strobe    = we_q ? wr_data_en : rd_data_en;
  assign last_beat = strobe && ((beat_q + LW'(1)) == len_q);
  assign timeout   = !strobe && (idle_q == IDLE_LIMIT);

  // State register.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; zero-length bursts skip the controller entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (pick_any) state_d = (sel_len == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: state_d = ST_XFER;
      ST_XFER:  if (last_beat || timeout) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Burst context, beat/watchdog counters, triggers and rr pointer.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      ptr_q     <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      abort_q   <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      idle_q    <= '0;
      gnt_q     <= '0;
      wr_trig_q <= 1'b0;
      rd_trig_q <= 1'b0;
    end else begin
      wr_trig_q <= 1'b0;
      rd_trig_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            idx_q     <= pick_idx;
            we_q      <= sel_we;
            addr_q    <= sel_addr;
            len_q     <= sel_len;
            gnt_q     <= pick_gnt;
            abort_q   <= 1'b0;
            beat_q    <= '0;
            idle_q    <= '0;
            wr_trig_q <= sel_we && (sel_len != '0);
            rd_trig_q <= !sel_we && (sel_len != '0);
          end
        end
        ST_XFER: begin
          if (strobe) begin
            beat_q <= beat_q + LW'(1);
            idle_q <= '0;
          end else begin
            idle_q <= idle_q + TOW'(1);
            if (timeout) abort_q <= 1'b1;
          end
        end
        ST_DONE: begin
          gnt_q <= '0;
          ptr_q <= (int'(idx_q) == NPORT - 1) ? '0 : idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign gnt            = gnt_q;
  assign done           = (state_q == ST_DONE) ? gnt_q : '0;
  assign err            = abort_q ? done : '0;
  assign wr_trig        = wr_trig_q;
  assign rd_trig        = rd_trig_q;
  assign wr_len         = len_q;
  assign rd_len         = len_q;
  assign wr_addr        = addr_q;
  assign rd_addr        = addr_q;
  assign wr_data        = wdata_arr[idx_q];
  assign port_rdata     = rd_data;
  assign port_wdata_en  = (wr_data_en && we_q) ? gnt_q : '0;
  assign port_rdata_vld = (rd_data_en && !we_q) ? gnt_q : '0;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: a table of arbitration scenarios, hand-written
// corner sequences (watchdog abort, reset mid-burst, idle strobes) and a
// randomized phase checked against a transaction-level round-robin model.
module tb_sdram_port_arbiter;
  import sdram_pkg::*;

  localparam int NPORT   = 2;
  localparam int AW      = 21;
  localparam int DW      = 16;
  localparam int LW      = 8;
  localparam int TIMEOUT = 4095;
  localparam int W       = 4 + 1 + AW + LW;  // {port, we, addr, len}

  logic                sclk = 1'b0;
  logic                srst_n = 1'b0;
  logic [NPORT-1:0]    req = '0, req_we = '0;
  logic [NPORT*AW-1:0] req_addr = '0;
  logic [NPORT*LW-1:0] req_len = '0;
  logic [NPORT*DW-1:0] req_wdata = '0;
  logic [NPORT-1:0]    gnt, port_wdata_en, port_rdata_vld, done, err;
  logic [DW-1:0]       port_rdata, wr_data;
  logic                wr_trig, rd_trig;
  logic [LW-1:0]       wr_len, rd_len;
  logic [AW-1:0]       wr_addr, rd_addr;
  logic                wr_data_en = 1'b0, rd_data_en = 1'b0;
  logic [DW-1:0]       rd_data = '0;
  arb_state_t          dbg_state;

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;
  logic [W-1:0] exp_q[$];

  sdram_port_arbiter #(
    .NPORT(NPORT), .AW(AW), .DW(DW), .LW(LW), .TIMEOUT(TIMEOUT)
  ) dut (
    .sclk(sclk), .srst_n(srst_n), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .gnt(gnt), .port_wdata_en(port_wdata_en), .port_rdata(port_rdata),
    .port_rdata_vld(port_rdata_vld), .done(done), .err(err),
    .wr_trig(wr_trig), .rd_trig(rd_trig), .wr_len(wr_len), .rd_len(rd_len),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_data(wr_data),
    .wr_data_en(wr_data_en), .rd_data(rd_data), .rd_data_en(rd_data_en),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 sclk = ~sclk;

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge sclk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] port_of(input logic [NPORT-1:0] g);
    for (int i = 0; i < NPORT; i++) if (g[i]) return 4'(i);
    return 4'hF;
  endfunction

  // Reference arbitration: first pending port at or after the pointer.
  function automatic int model_pick(input logic [NPORT-1:0] pend, input int ptr);
    for (int k = 0; k < NPORT; k++) if (pend[(ptr + k) % NPORT]) return (ptr + k) % NPORT;
    return -1;
  endfunction

  task automatic set_port(input int p, input logic we, input logic [AW-1:0] addr,
                          input logic [LW-1:0] len);
    req_we[p]              = we;
    req_addr[p*AW +: AW]   = addr;
    req_len[p*LW +: LW]    = len;
    req_wdata[p*DW +: DW]  = DW'($urandom);
  endtask

  // ---------------- scoreboard: every trigger must match the next expected burst ----------------
  always @(negedge sclk) begin
    if (wr_trig || rd_trig) begin
      if (exp_q.size() == 0) begin
        check("trig_unexpected", 64'(wr_trig | rd_trig), 64'd0);
      end else begin
        logic [W-1:0] e, got;
        e   = exp_q.pop_front();
        got = {port_of(gnt), wr_trig, (wr_trig ? wr_addr : rd_addr), (wr_trig ? wr_len : rd_len)};
        check("trig_desc", got, e);
      end
    end
  end

  // ---------------- driver: serve one burst, port p expected to win ----------------
  // Called at a negedge in IDLE with req already driven.
  task automatic serve(input int p, input logic [NPORT-1:0] drop);
    logic we, s, o;
    logic [LW-1:0] len;
    logic [NPORT-1:0] oh;
    int beats, guard;
    we  = req_we[p];
    len = req_len[p*LW +: LW];
    oh  = NPORT'(1) << p;
    if (len != 0) exp_q.push_back({4'(p), we, req_addr[p*AW +: AW], len});
    tick();
    check("gnt", gnt, oh);
    check("wr_trig", wr_trig, we && (len != 0));
    check("rd_trig", rd_trig, !we && (len != 0));
    req = req & ~drop;
    if (len == 0) begin
      check("done_len0", done, oh);
      check("err_len0", err, '0);
    end else begin
      // A strobe during ISSUE must not be counted as a beat.
      if ($urandom_range(0, 1) == 1) begin
        if (we) wr_data_en = 1'b1; else rd_data_en = 1'b1;
      end
      tick();
      wr_data_en = 1'b0;
      rd_data_en = 1'b0;
      check("trig_pulse", {wr_trig, rd_trig}, 2'b00);
      beats = 0;
      guard = 0;
      while (beats < int'(len) && guard < 40 * int'(len) + 40) begin
        s = ($urandom_range(0, 3) != 0) || (guard > 20 * int'(len));
        o = 1'($urandom_range(0, 1));
        wr_data_en = we ? s : o;
        rd_data_en = we ? o : s;
        rd_data    = DW'($urandom);
        #1;
        check("wdata_en", port_wdata_en, (we && wr_data_en) ? oh : '0);
        check("rdata_vld", port_rdata_vld, (!we && rd_data_en) ? oh : '0);
        check("port_rdata", port_rdata, rd_data);
        if (we) check("wr_data", wr_data, req_wdata[p*DW +: DW]);
        check("no_early_done", done, '0);
        if (s) beats++;
        guard++;
        tick();
      end
      wr_data_en = 1'b0;
      rd_data_en = 1'b0;
      check("done", done, oh);
      check("err", err, '0);
    end
    tick();
    check("gnt_clear", gnt, '0);
    check("done_clear", done, '0);
    model_ptr = (p + 1) % NPORT;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NPORT-1:0] req_v;
    logic             we;
    logic [AW-1:0]    addr;
    logic [LW-1:0]    len;
    logic [NPORT-1:0] drop;
    int               exp_port;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [NPORT-1:0] pend;
    int n, w;

    tbl[0] = '{2'b11, 1'b0, 21'h00200, 8'd2,   2'b01, 0};  // both read: port0 first
    tbl[1] = '{2'b10, 1'b0, 21'h00300, 8'd2,   2'b10, 1};  // then port1, ptr back to 0
    tbl[2] = '{2'b01, 1'b1, 21'h00100, 8'd4,   2'b01, 0};  // port0 write len 4
    tbl[3] = '{2'b10, 1'b1, 21'h1ABCD, 8'd0,   2'b10, 1};  // len 0: no trigger
    tbl[4] = '{2'b11, 1'b1, 21'h00040, 8'd1,   2'b01, 0};  // port1 keeps holding req
    tbl[5] = '{2'b11, 1'b1, 21'h00041, 8'd1,   2'b00, 1};  // alternation 1,0,1
    tbl[6] = '{2'b11, 1'b0, 21'h00042, 8'd3,   2'b01, 0};
    tbl[7] = '{2'b10, 1'b1, 21'h00043, 8'd2,   2'b10, 1};
    tbl[8] = '{2'b01, 1'b0, 21'h1FFFFF, 8'd255, 2'b01, 0}; // longest burst

    // ---- reset ----
    repeat (3) tick();
    check("rst_gnt", gnt, '0);
    check("rst_trig", {wr_trig, rd_trig}, 2'b00);
    srst_n = 1'b1;
    tick();
    check("rst_done", done, '0);
    check("rst_err", err, '0);
    check("rst_len", {wr_len, rd_len}, '0);
    check("rst_addr", {wr_addr, rd_addr}, '0);
    check("rst_state", dbg_state, ST_IDLE);

    // ---- table-driven arbitration ----
    for (int i = 0; i < 9; i++) begin
      for (int p = 0; p < NPORT; p++)
        if (tbl[i].req_v[p]) set_port(p, tbl[i].we, tbl[i].addr, tbl[i].len);
      req = tbl[i].req_v;
      serve(tbl[i].exp_port, tbl[i].drop);
    end

    // ---- reset during a burst (pointer is 1 here) ----
    set_port(0, 1'b0, 21'h00777, 8'd8);
    exp_q.push_back({4'd0, 1'b0, 21'h00777, 8'd8});
    req = 2'b01;
    tick();
    check("rst_burst_gnt", gnt, 2'b01);
    req = '0;
    tick();
    repeat (3) begin
      rd_data_en = 1'b1;
      tick();
    end
    rd_data_en = 1'b0;
    srst_n = 1'b0;
    #1;
    check("async_gnt", gnt, '0);
    check("async_trig", {wr_trig, rd_trig}, 2'b00);
    check("async_done", done, '0);
    check("async_len", rd_len, '0);
    check("async_state", dbg_state, ST_IDLE);
    repeat (2) tick();
    srst_n = 1'b1;
    model_ptr = 0;
    repeat (4) begin
      tick();
      check("post_rst_quiet", {gnt, done}, '0);
    end
    // Pointer must be back at port 0 after reset.
    set_port(0, 1'b1, 21'h00010, 8'd3);
    set_port(1, 1'b1, 21'h00020, 8'd3);
    req = 2'b11;
    serve(model_pick(req, model_ptr), 2'b11);

    // ---- watchdog: read len 8, only 5 strobes ----
    set_port(1, 1'b0, 21'h0DEAD, 8'd8);
    exp_q.push_back({4'd1, 1'b0, 21'h0DEAD, 8'd8});
    req = 2'b10;
    tick();
    check("wd_gnt", gnt, 2'b10);
    req = '0;
    tick();
    repeat (5) begin
      rd_data_en = 1'b1;
      tick();
    end
    rd_data_en = 1'b0;
    n = 0;
    while (done == '0 && n < TIMEOUT + 20) begin
      tick();
      n++;
    end
    check("wd_cycles", 64'(n), 64'(TIMEOUT));
    check("wd_done", done, 2'b10);
    check("wd_err", err, 2'b10);
    tick();
    check("wd_gnt_clear", gnt, '0);
    check("wd_state", dbg_state, ST_IDLE);
    model_ptr = 0;

    // ---- randomized bursts against the round-robin model ----
    pend = '0;
    for (int b = 0; b < 40; b++) begin
      for (int p = 0; p < NPORT; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p] = 1'b1;
          set_port(p, 1'($urandom_range(0, 1)), AW'($urandom), LW'($urandom_range(0, 10)));
        end
      end
      if (pend == '0) begin
        w = $urandom_range(0, NPORT - 1);
        pend[w] = 1'b1;
        set_port(w, 1'($urandom_range(0, 1)), AW'($urandom), LW'($urandom_range(1, 10)));
      end
      req = pend;
      w = model_pick(pend, model_ptr);
      serve(w, NPORT'(1) << w);
      pend[w] = 1'b0;
    end
    req = '0;

    // ---- strobes while idle are ignored ----
    repeat (3) begin
      wr_data_en = 1'b1;
      rd_data_en = 1'b1;
      tick();
      check("idle_strobe", {gnt, done, err}, '0);
    end
    wr_data_en = 1'b0;
    rd_data_en = 1'b0;
    check("idle_state", dbg_state, ST_IDLE);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
